// File: rtl/brdec_pipe.sv
// Pipelined fetch-bundle branch pre-decoder: per-slot decode, first-branch
// select and valid-mask truncation, an internal return-address stack with
// flush checkpoint/restore, and a registered valid/ready result stage.

// Single-slot pre-decoder for RV64 control transfers.
// Branch types: 00 conditional, 01 direct jump, 10 call, 11 indirect/return.
// ras_ctl: 00 none, 01 push, 10 pop, 11 pop-then-push (link-register hints).
module brdec_way (
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    input  logic [63:0] ras_data,
    output logic        br_flag,
    output logic [1:0]  br_typ,
    output logic [63:0] br_tar,
    output logic [1:0]  ras_ctl
);
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        rd_link;
    logic        rs1_link;
    logic [63:0] imm_j;
    logic [63:0] imm_b;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign rs1      = inst[19:15];
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign imm_j    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_b    = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    // Classify the instruction and derive its predicted target and RAS action
    always_comb begin
        br_flag = 1'b0;
        br_typ  = 2'b00;
        br_tar  = 64'd0;
        ras_ctl = 2'b00;
        case (opcode)
            7'b1100011: begin
                br_flag = 1'b1;
                br_typ  = 2'b00;
                br_tar  = pc + imm_b;
            end
            7'b1101111: begin
                br_flag = 1'b1;
                br_typ  = rd_link ? 2'b10 : 2'b01;
                br_tar  = pc + imm_j;
                ras_ctl = rd_link ? 2'b01 : 2'b00;
            end
            7'b1100111: begin
                br_flag = 1'b1;
                br_typ  = rd_link ? 2'b10 : 2'b11;
                // only link-register indirects are predictable here (via RAS)
                br_tar  = rs1_link ? ras_data : 64'd0;
                if (rd_link && rs1_link && (rd != rs1)) ras_ctl = 2'b11;
                else if (rd_link)                       ras_ctl = 2'b01;
                else if (rs1_link)                      ras_ctl = 2'b10;
                else                                    ras_ctl = 2'b00;
            end
            default: ;
        endcase
    end
endmodule

module brdec_pipe #(
    parameter int FETCH_W   = 8,
    parameter int RAS_DEPTH = 8,
    parameter int POS_W     = $clog2(FETCH_W),
    parameter int PTR_W     = $clog2(RAS_DEPTH),
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [63:0]          pc_i,
    input  logic [FETCH_W*32-1:0] inst_i,
    input  logic                 valid_override_i,
    input  logic                 flush_i,
    input  logic [PTR_W-1:0]     flush_ras_ptr_i,
    input  logic [CNT_W-1:0]     flush_ras_cnt_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [63:0]          pc_o,
    output logic [FETCH_W-1:0]   inst_valid_o,
    output logic                 br_exist_o,
    output logic                 btb_we_o,
    output logic [POS_W-1:0]     btb_br_pos_o,
    output logic [1:0]           btb_br_typ_o,
    output logic [63:0]          btb_br_tar_o,
    output logic [PTR_W-1:0]     ras_ptr_o,
    output logic [CNT_W-1:0]     ras_cnt_o,
    output logic                 ras_underflow_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [FETCH_W-1:0][63:0] slot_pc;
    logic [FETCH_W-1:0][63:0] slot_tar;
    logic [FETCH_W-1:0][1:0]  slot_typ;
    logic [FETCH_W-1:0][1:0]  slot_ctl;
    logic [FETCH_W-1:0]       slot_br;

    logic [63:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [63:0]      ras_top;

    logic               found;
    logic [POS_W-1:0]   sel_pos;
    logic [FETCH_W-1:0] sel_mask;
    logic [FETCH_W-1:0] nxt_iv;
    logic [POS_W-1:0]   nxt_pos;
    logic               nxt_be;
    logic [1:0]         nxt_typ;
    logic [63:0]        nxt_tar;
    logic [1:0]         sel_ctl;
    logic [63:0]        ret_addr;
    logic               accept;
    logic               ras_upd;

    logic [PTR_W-1:0] ptr_n;
    logic [CNT_W-1:0] cnt_n;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic             uf_n;
    logic [CNT_W-1:0] flush_cnt;

    // memory is not reset, so an empty stack must read as zero
    assign ras_top = (ras_cnt != '0) ? ras_mem[ras_ptr] : 64'd0;

    genvar g;
    generate
        for (g = 0; g < FETCH_W; g++) begin : g_way
            assign slot_pc[g] = pc_i + 64'(4 * g);
            brdec_way u_way (
                .inst     (inst_i[32*g +: 32]),
                .pc       (slot_pc[g]),
                .ras_data (ras_top),
                .br_flag  (slot_br[g]),
                .br_typ   (slot_typ[g]),
                .br_tar   (slot_tar[g]),
                .ras_ctl  (slot_ctl[g])
            );
        end
    endgenerate

    // Priority-select the first branch; keep slots up to and including it
    always_comb begin
        found    = 1'b0;
        sel_pos  = '0;
        sel_mask = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            sel_mask[k] = ~found;
            if (!found && slot_br[k]) begin
                found   = 1'b1;
                sel_pos = POS_W'(k);
            end
        end
    end

    assign nxt_be   = found & ~valid_override_i;
    assign nxt_iv   = valid_override_i ? '0 : sel_mask;
    assign nxt_pos  = valid_override_i ? '0 : sel_pos;
    assign nxt_typ  = nxt_be ? slot_typ[sel_pos] : 2'b00;
    assign nxt_tar  = nxt_be ? slot_tar[sel_pos] : 64'd0;
    assign sel_ctl  = nxt_be ? slot_ctl[sel_pos] : 2'b00;
    assign ret_addr = slot_pc[sel_pos] + 64'd4;

    assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign ras_upd    = accept & nxt_be;
    assign btb_we_o   = out_valid_o & br_exist_o;
    assign flush_cnt  = (flush_ras_cnt_i > CNT_MAX) ? CNT_MAX : flush_ras_cnt_i;

    // Next RAS pointer/count and write port for the selected slot's action
    always_comb begin
        ptr_n   = ras_ptr;
        cnt_n   = ras_cnt;
        wr_en   = 1'b0;
        wr_addr = ras_ptr;
        uf_n    = 1'b0;
        case (sel_ctl)
            2'b01: begin
                ptr_n   = ras_ptr + PTR_W'(1);
                cnt_n   = (ras_cnt == CNT_MAX) ? ras_cnt : ras_cnt + CNT_W'(1);
                wr_en   = 1'b1;
                wr_addr = ras_ptr + PTR_W'(1);
            end
            2'b10: begin
                if (ras_cnt != '0) begin
                    ptr_n = ras_ptr - PTR_W'(1);
                    cnt_n = ras_cnt - CNT_W'(1);
                end else begin
                    uf_n = 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                cnt_n = (ras_cnt == '0) ? CNT_W'(1) : ras_cnt;
            end
            default: ;
        endcase
    end

    // RAS pointer/count: flush restores the checkpoint, accept applies the action
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (flush_i) begin
            ras_ptr <= flush_ras_ptr_i;
            ras_cnt <= flush_cnt;
        end else if (ras_upd) begin
            ras_ptr <= ptr_n;
            ras_cnt <= cnt_n;
        end
    end

    // RAS storage write (accept already excludes flush cycles)
    always_ff @(posedge clk_i) begin
        if (ras_upd && wr_en) ras_mem[wr_addr] <= ret_addr;
    end

    // Result-valid flag of the F2 handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)            out_valid_o <= 1'b0;
        else if (flush_i)     out_valid_o <= 1'b0;
        else if (accept)      out_valid_o <= 1'b1;
        else if (out_ready_i) out_valid_o <= 1'b0;
    end

    // Result payload, loaded only on accept so it holds under backpressure
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o            <= 64'd0;
            inst_valid_o    <= '0;
            br_exist_o      <= 1'b0;
            btb_br_pos_o    <= '0;
            btb_br_typ_o    <= 2'b00;
            btb_br_tar_o    <= 64'd0;
            ras_ptr_o       <= '0;
            ras_cnt_o       <= '0;
            ras_underflow_o <= 1'b0;
        end else if (accept) begin
            pc_o            <= pc_i;
            inst_valid_o    <= nxt_iv;
            br_exist_o      <= nxt_be;
            btb_br_pos_o    <= nxt_pos;
            btb_br_typ_o    <= nxt_typ;
            btb_br_tar_o    <= nxt_tar;
            ras_ptr_o       <= ras_ptr;
            ras_cnt_o       <= ras_cnt;
            ras_underflow_o <= uf_n;
        end
    end
endmodule
